// File: rtl/api_phy_ctrl.sv
`default_nettype none
// ============================================================================
// api_phy_ctrl : SPI-style serial engine moving TX FIFO words out to miner
//                channels and returned words into the RX FIFO.
// Revision     : 1.0
// ============================================================================
module api_phy_ctrl #(
  parameter int CH_MAX = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       txfifo_dout,
  input  logic [10:0]       txcnt,
  output logic              txfifo_pop,
  output logic              rx_fifo_wr_en,
  output logic [31:0]       rx_fifo_din,
  output logic [3:0]        miner_id,
  output logic [4:0]        work_cnt,
  input  logic              reg_flush,
  input  logic [27:0]       reg_timeout,
  input  logic [7:0]        reg_sck,
  input  logic [5:0]        reg_ch_num,
  input  logic [7:0]        reg_word_num,
  output logic [2:0]        reg_state,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic [CH_MAX-1:0] spi_cs_n,
  input  logic [CH_MAX-1:0] spi_miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_POP   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHIFT = 3'd4,
    ST_STORE = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  localparam logic [5:0] CH_MAX_C = 6'(CH_MAX);

  state_t            state_q, state_d;
  logic [27:0]       timer_q, timer_d;
  logic [5:0]        ch_num_q, ch_num_d;
  logic [7:0]        word_num_q, word_num_d;
  logic [7:0]        sck_div_q, sck_div_d;
  logic [3:0]        ch_q, ch_d;
  logic [7:0]        word_q, word_d;
  logic [5:0]        bit_q, bit_d;
  logic [7:0]        div_q, div_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [CH_MAX-1:0] cs_n_q, cs_n_d;
  logic [30:0]       tx_sr_q, tx_sr_d;
  logic [31:0]       rx_sr_q, rx_sr_d;
  logic [31:0]       rx_din_q, rx_din_d;
  logic [3:0]        miner_id_q, miner_id_d;
  logic [4:0]        work_cnt_q, work_cnt_d;
  logic              pop_c, wr_c;

  logic [13:0]       need_words;
  logic              last_word;
  logic              last_ch;

  assign need_words = {8'd0, ch_num_q} * {6'd0, word_num_q};
  assign last_word  = !((word_q + 8'd1) < word_num_q);
  assign last_ch    = !(({2'b00, ch_q} + 6'd1) < ch_num_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ch_num_d   = ch_num_q;
    word_num_d = word_num_q;
    sck_div_d  = sck_div_q;
    ch_d       = ch_q;
    word_d     = word_q;
    bit_d      = bit_q;
    div_d      = div_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_din_d   = rx_din_q;
    miner_id_d = miner_id_q;
    work_cnt_d = work_cnt_q;
    pop_c      = 1'b0;
    wr_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ch_num_d   = (reg_ch_num > CH_MAX_C) ? CH_MAX_C : reg_ch_num;
        word_num_d = reg_word_num;
        sck_div_d  = reg_sck;
        timer_d    = reg_timeout;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (timer_q != 28'd0) begin
          timer_d = timer_q - 28'd1;
        end else if (ch_num_q == 6'd0 || word_num_q == 8'd0) begin
          state_d = ST_IDLE;
        end else if ({3'd0, txcnt} >= need_words) begin
          ch_d      = 4'd0;
          word_d    = 8'd0;
          cs_n_d    = '1;
          cs_n_d[0] = 1'b0;
          state_d   = ST_POP;
        end
      end
      ST_POP: begin
        pop_c   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        tx_sr_d = txfifo_dout[30:0];
        mosi_d  = txfifo_dout[31];
        bit_d   = 6'd0;
        div_d   = 8'd0;
        sck_d   = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == sck_div_q) begin
          div_d = 8'd0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[30:0], spi_miso[ch_q]};
            bit_d   = bit_q + 6'd1;
          end else begin
            sck_d = 1'b0;
            // The 32nd falling edge closes the word; no further mosi advance.
            if (bit_q == 6'd32) begin
              rx_din_d   = rx_sr_q;
              miner_id_d = ch_q;
              work_cnt_d = (word_q > 8'd31) ? 5'd31 : word_q[4:0];
              state_d    = ST_STORE;
            end else begin
              mosi_d  = tx_sr_q[30];
              tx_sr_d = {tx_sr_q[29:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_STORE: begin
        wr_c  = 1'b1;
        div_d = 8'd0;
        // Release the channel now so the gap spans the whole NEXT wait.
        if (last_word) cs_n_d = '1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (!last_word) begin
          word_d  = word_q + 8'd1;
          state_d = ST_POP;
        end else if (div_q == sck_div_q) begin
          div_d = 8'd0;
          if (!last_ch) begin
            ch_d                 = ch_q + 4'd1;
            word_d               = 8'd0;
            cs_n_d[ch_q + 4'd1]  = 1'b0;
            state_d              = ST_POP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reg_flush) begin
      state_d    = ST_IDLE;
      cs_n_d     = '1;
      sck_d      = 1'b0;
      bit_d      = 6'd0;
      word_d     = 8'd0;
      ch_d       = 4'd0;
      div_d      = 8'd0;
      rx_din_d   = rx_din_q;
      miner_id_d = miner_id_q;
      work_cnt_d = work_cnt_q;
      pop_c      = 1'b0;
      wr_c       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= 28'd0;
      ch_num_q   <= 6'd0;
      word_num_q <= 8'd0;
      sck_div_q  <= 8'd0;
      ch_q       <= 4'd0;
      word_q     <= 8'd0;
      bit_q      <= 6'd0;
      div_q      <= 8'd0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_sr_q    <= 31'd0;
      rx_sr_q    <= 32'd0;
      rx_din_q   <= 32'd0;
      miner_id_q <= 4'd0;
      work_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ch_num_q   <= ch_num_d;
      word_num_q <= word_num_d;
      sck_div_q  <= sck_div_d;
      ch_q       <= ch_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_din_q   <= rx_din_d;
      miner_id_q <= miner_id_d;
      work_cnt_q <= work_cnt_d;
    end
  end

  assign txfifo_pop    = pop_c;
  assign rx_fifo_wr_en = wr_c;
  assign rx_fifo_din   = rx_din_q;
  assign miner_id      = miner_id_q;
  assign work_cnt      = work_cnt_q;
  assign reg_state     = state_q;
  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs_n      = cs_n_q;

endmodule
`default_nettype wire
